// File: rtl/phase_sequencer.sv
// Round-robin phase sequencer: walks N_PHASES sub-blocks through an enable/done handshake.
// Optional per-phase watchdog is built when PHASE_TIMEOUT_EN is defined.
module phase_sequencer #(
  parameter int unsigned N_PHASES       = 3,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned FRAME_W        = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ena,
  input  logic                pause_i,
  input  logic [N_PHASES-1:0] skip_i,
  input  logic [N_PHASES-1:0] phase_done_i,
  output logic [N_PHASES-1:0] phase_en_o,
  output logic [IDX_W-1:0]    phase_idx_o,
  output logic                busy_o,
  output logic                frame_tick_o,
  output logic [FRAME_W-1:0]  frame_cnt_o,
  output logic                timeout_o,
  output logic                timeout_flag_o
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("phase_sequencer: TIMEOUT_CYCLES must be at least 2");
  end
  if ((2 ** IDX_W) < N_PHASES) begin : g_bad_idx_w
    $error("phase_sequencer: IDX_W too narrow for N_PHASES");
  end

  logic [0:0]          state_q, state_d;
  logic [N_PHASES-1:0] en_q, en_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                tick_q, tick_d;
  logic [FRAME_W-1:0]  cnt_q, cnt_d;

  logic             first_ok, next_ok, cur_done, expire, advance;
  logic [IDX_W-1:0] first_idx, next_idx;

  function automatic logic [N_PHASES-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = '0;
    for (int k = 0; k < int'(N_PHASES); k++) begin
      onehot[k] = (i == IDX_W'(k));
    end
  endfunction

  // Lowest non-skipped phase overall and above the current one; done of the current phase.
  always_comb begin
    first_ok  = 1'b0;
    first_idx = '0;
    next_ok   = 1'b0;
    next_idx  = '0;
    cur_done  = 1'b0;
    for (int k = int'(N_PHASES) - 1; k >= 0; k--) begin
      if (!skip_i[k]) begin
        first_ok  = 1'b1;
        first_idx = IDX_W'(k);
      end
      if (!skip_i[k] && (IDX_W'(k) > idx_q)) begin
        next_ok  = 1'b1;
        next_idx = IDX_W'(k);
      end
      if (IDX_W'(k) == idx_q) begin
        cur_done = phase_done_i[k];
      end
    end
  end

  assign advance = ena && (state_q == S_RUN) && (cur_done || expire);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    idx_d   = idx_q;
    tick_d  = 1'b0;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (ena && !pause_i && first_ok) begin
          state_d = S_RUN;
          idx_d   = first_idx;
          en_d    = onehot(first_idx);
        end
      end
      S_RUN: begin
        if (advance) begin
          if (next_ok) begin
            idx_d = next_idx;
            en_d  = onehot(next_idx);
          end else begin
            tick_d = 1'b1;
            cnt_d  = cnt_q + FRAME_W'(1);
            // Frame boundary: the only place a pause or an all-skipped mask stops the rotation.
            if (pause_i || !first_ok) begin
              state_d = S_IDLE;
              en_d    = '0;
            end else begin
              idx_d = first_idx;
              en_d  = onehot(first_idx);
            end
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        en_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      en_q    <= '0;
      idx_q   <= '0;
      tick_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
      idx_q   <= idx_d;
      tick_q  <= tick_d;
      cnt_q   <= cnt_d;
    end
  end

  assign phase_en_o   = en_q;
  assign phase_idx_o  = idx_q;
  assign busy_o       = (state_q == S_RUN);
  assign frame_tick_o = tick_q;
  assign frame_cnt_o  = cnt_q;

`ifdef PHASE_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            to_q, to_d;
  logic            flag_q, flag_d;

  // A real done on the expiry edge suppresses the timeout report.
  assign expire = !cur_done && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

  always_comb begin
    wd_d   = wd_q;
    to_d   = 1'b0;
    flag_d = flag_q;
    if (ena) begin
      if ((state_q == S_IDLE) || advance) begin
        wd_d = '0;
      end else begin
        wd_d = wd_q + WD_W'(1);
      end
      if ((state_q == S_RUN) && expire) begin
        to_d   = 1'b1;
        flag_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_q   <= '0;
      to_q   <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      wd_q   <= wd_d;
      to_q   <= to_d;
      flag_q <= flag_d;
    end
  end

  assign timeout_o      = to_q;
  assign timeout_flag_o = flag_q;
`else
  assign expire         = 1'b0;
  assign timeout_o      = 1'b0;
  assign timeout_flag_o = 1'b0;
`endif

endmodule

// File: doc/phase_sequencer.md
# phase_sequencer

Parametrised round-robin phase sequencer that drives N_PHASES sub-blocks (input sampling, game action, display refresh, …) through an enable/done handshake, one phase at a time. It is the next-generation replacement for the hard-wired three-state input/action/display controller in the flappy-bird top level. It adds a per-phase skip mask, frame pause, a frame counter and an optional per-phase watchdog. It sits in the top module between the game sub-blocks and the tile enable, and runs on the rising edge.

## Interface
- N_PHASES, 3: number of handshaked phases, 1..8.
- IDX_W, 2: width of phase_idx_o; must satisfy 2^IDX_W ≥ N_PHASES.
- FRAME_W, 8: width of frame counter.
- TIMEOUT_CYCLES, 1024: watchdog limit in cycles per phase, ≥ 2. Used only with PHASE_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ena  in  1  global enable; low freezes all state, counters and outputs.
- pause_i  in  1  request to stop at the next frame boundary.
- skip_i  in  N_PHASES  bit k=1 excludes phase k from the rotation.
- phase_done_i  in  N_PHASES  done strobe/level from phase k.
- phase_en_o  out  N_PHASES  one-hot (or zero) enable to phases.
- phase_idx_o  out  IDX_W  index of current or last phase.
- busy_o  out  1  high in RUN.
- frame_tick_o  out  1  one-cycle pulse when a frame completes.
- frame_cnt_o  out  FRAME_W  completed-frame count, wraps.
- timeout_o  out  1  one-cycle pulse on watchdog expiry.
- timeout_flag_o  out  1  sticky watchdog flag, cleared only by reset.

## Operation
- Reset (async, immediate, also mid-phase) forces the following values: state IDLE; phase_en_o=0; phase_idx_o=0; busy_o=0; frame_tick_o=0; frame_cnt_o=0; timeout_o=0; timeout_flag_o=0; watchdog=0.
- All transitions below require ena=1. With ena=0 nothing changes, and frame_tick_o and timeout_o are held low.
- IDLE:
  - If pause_i=0 and skip_i has at least one zero, go to RUN.
  - The entry phase is the lowest non-skipped index. phase_idx_o and the one-hot phase_en_o are loaded on that edge.
  - Otherwise stay in IDLE.
- RUN, with current index idx and phase_en_o[idx]=1:
  - The sequencer samples phase_done_i[idx] each edge. Done bits of non-current phases are ignored.
  - On done, pick next = the lowest non-skipped index > idx.
  - If no such index exists, the frame completes:
    - Pulse frame_tick_o and increment frame_cnt_o (modulo 2^FRAME_W).
    - Take next = the lowest non-skipped index overall.
  - If the frame completed and (pause_i=1 or all of skip_i=1), go to IDLE: phase_en_o=0, phase_idx_o keeps the last idx.
  - Otherwise load next into phase_idx_o and phase_en_o on the same edge.
- skip_i is sampled only at advance/entry decisions. Changing it mid-phase does not disturb the active phase.
- With a single active phase, every done completes a frame, and the same phase_en_o bit stays high continuously.
- A done held high is counted once per edge. A phase that keeps done high advances on every edge.

## Timing
- IDLE→RUN: phase_en_o asserts on the first edge where ena=1, pause_i=0 and skip_i has a zero.
- Handoff has zero dead cycles:
  - done sampled at edge t → old enable low and new enable high after edge t.
  - frame_tick_o is high for exactly the cycle after edge t.
- A done that is high on the first edge after enable assertion is honoured, giving a minimum phase length of 1 cycle.
- A pause request is honoured only at a frame boundary. A partially completed frame always finishes.
- ena low mid-phase: phase_en_o stays asserted and the watchdog holds. The sequence resumes on the next edge with ena=1.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- PHASE_TIMEOUT_EN defined:
  - A watchdog clears on every phase entry and increments each RUN cycle with ena=1.
  - When it reaches TIMEOUT_CYCLES−1 without done, the phase is treated as done: normal advance, timeout_o pulses 1 cycle, and timeout_flag_o sets.
  - A done arriving on the expiry edge wins; no timeout is reported.
- PHASE_TIMEOUT_EN undefined: no watchdog logic; RUN waits indefinitely; timeout_o and timeout_flag_o are tied to 0.

## Test plan
- Reset, N_PHASES=3, skip=000, done each 5 cycles → en sequence 001,010,100,001; frame_tick once per 3 dones; frame_cnt=1 after the first wrap.
- skip=010, done held high constantly → en alternates 001/100 every cycle; phase 1 never enabled; frame_tick every 2 cycles.
- pause_i raised during phase 1 → phases 1,2 finish; frame_cnt increments; then IDLE with en=000 and idx=2. Dropping pause → en=001 next edge.
- FRAME_W=2, run 5 frames → frame_cnt 1,2,3,0,1.
- PHASE_TIMEOUT_EN, TIMEOUT_CYCLES=16, phase 0 never done → advance after 16 cycles; timeout_o 1-cycle pulse; timeout_flag_o stays 1 until rst_n low.
- rst_n low mid-phase 1 → all outputs at reset values immediately. ena=0 for 10 cycles mid-phase → en and idx unchanged, no ticks.
